// File: rtl/max_pool2d_stream.sv
// Streaming KxK / stride-K signed max-pool engine with valid/ready on both sides.
// Optional build macro MAX_POOL_RELU_EN clamps negative results to zero at output-register load.
module max_pool2d_stream #(
    parameter int WIDTH = 8,
    parameter int K     = 2,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_last
);

    localparam int NB = IMG_W / K;
    localparam int KW = $clog2(K);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    if (K < 2) begin : g_bad_k
        $error("max_pool2d_stream: K must be >= 2");
    end
    if (IMG_W % K != 0) begin : g_bad_w
        $error("max_pool2d_stream: IMG_W must be a multiple of K");
    end
    if (IMG_H % K != 0) begin : g_bad_h
        $error("max_pool2d_stream: IMG_H must be a multiple of K");
    end

    function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH-1:0] v);
`ifdef MAX_POOL_RELU_EN
        return v[WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // kc/kr: position inside the window; bi: window column (= col/K); row: frame row.
    logic [KW-1:0]           kc_q, kc_d, kr_q, kr_d;
    logic [BW-1:0]           bi_q, bi_d;
    logic [RW-1:0]           row_q, row_d;
    logic signed [WIDTH-1:0] hmax_q, hmax_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic signed [WIDTH-1:0] rowbuf_q [NB];

    logic                    accept, buf_we;
    logic signed [WIDTH-1:0] buf_wdata, h, vmax;
    logic                    col_last_k, row_last_k, blk_last, row_last;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready && !clear;
    assign col_last_k = (kc_q == KW'(K - 1));
    assign row_last_k = (kr_q == KW'(K - 1));
    assign blk_last   = (bi_q == BW'(NB - 1));
    assign row_last   = (row_q == RW'(IMG_H - 1));
    assign h          = smax(hmax_q, in_data);
    assign vmax       = smax(rowbuf_q[bi_q], h);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        kc_d        = kc_q;
        kr_d        = kr_q;
        bi_d        = bi_q;
        row_d       = row_q;
        hmax_d      = hmax_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        buf_we      = 1'b0;
        buf_wdata   = h;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (clear) begin
            kc_d        = '0;
            kr_d        = '0;
            bi_d        = '0;
            row_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            hmax_d = (kc_q == '0) ? in_data : h;
            if (col_last_k) begin
                kc_d = '0;
                if (blk_last) begin
                    bi_d  = '0;
                    kr_d  = row_last_k ? '0 : kr_q + 1'b1;
                    row_d = row_last ? '0 : row_q + 1'b1;
                end else begin
                    bi_d = bi_q + 1'b1;
                end
                // Last window row produces the result; earlier rows fold into the buffer.
                if (row_last_k) begin
                    out_valid_d = 1'b1;
                    out_data_d  = clamp(vmax);
                    out_last_d  = blk_last && row_last;
                end else begin
                    buf_we    = 1'b1;
                    buf_wdata = (kr_q == '0) ? h : vmax;
                end
            end else begin
                kc_d = kc_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments on all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc_q        <= '0;
            kr_q        <= '0;
            bi_q        <= '0;
            row_q       <= '0;
            hmax_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            kc_q        <= kc_d;
            kr_q        <= kr_d;
            bi_q        <= bi_d;
            row_q       <= row_d;
            hmax_q      <= hmax_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // NOTE: the row buffer has no reset; every entry is written on row%K==0 before it is read.
    always_ff @(posedge clk) begin
        if (buf_we) rowbuf_q[bi_q] <= buf_wdata;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_max_pool2d_stream.sv
// Bench for max_pool2d_stream on a 4x4 frame, K=2: table vectors, stall/clear/reset
// sequences, back-to-back frames and randomized frames against a window-max model.
module tb_max_pool2d_stream;

    localparam int WIDTH = 8;
    localparam int K     = 2;
    localparam int W     = 4;
    localparam int H     = 4;
    localparam int NPIX  = W * H;
    localparam int NRES  = (W / K) * (H / K);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clear = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b1;
    logic signed [WIDTH-1:0] in_data = '0;
    logic                    in_ready, out_valid, out_last;
    logic signed [WIDTH-1:0] out_data;

    max_pool2d_stream #(.WIDTH(WIDTH), .K(K), .IMG_W(W), .IMG_H(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    typedef int frame_t [NPIX];
    typedef int res_t [NRES];
    typedef struct packed {
        logic signed [WIDTH-1:0] d;
        logic                    l;
        logic [31:0]             beat;
    } obs_t;
    typedef struct packed {
        logic [NPIX*8-1:0] pix;
        logic [NRES*8-1:0] exp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc_cnt  = 0;
    bit   rand_bp  = 1'b0;
    obs_t got [$];

    task automatic check(input string name, input integer act, input integer exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int relu_f(input int x);
`ifdef MAX_POOL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    // Reference: maximum over each KxK tile of the frame, in raster order of tiles.
    function automatic res_t ref_pool(input frame_t f);
        res_t r;
        for (int wy = 0; wy < H / K; wy++)
            for (int wx = 0; wx < W / K; wx++) begin
                int m = f[wy * K * W + wx * K];
                for (int dy = 0; dy < K; dy++)
                    for (int dx = 0; dx < K; dx++)
                        if (f[(wy * K + dy) * W + wx * K + dx] > m) m = f[(wy * K + dy) * W + wx * K + dx];
                r[wy * (W / K) + wx] = relu_f(m);
            end
        return r;
    endfunction

    function automatic vec_t mk(input frame_t f, input res_t e);
        vec_t v;
        for (int i = 0; i < NPIX; i++) v.pix[i*8 +: 8] = 8'(f[i]);
        for (int i = 0; i < NRES; i++) v.exp[i*8 +: 8] = 8'(e[i]);
        return v;
    endfunction

    function automatic frame_t vframe(input vec_t v);
        frame_t f;
        for (int i = 0; i < NPIX; i++) f[i] = $signed(v.pix[i*8 +: 8]);
        return f;
    endfunction

    function automatic res_t vexp(input vec_t v);
        res_t e;
        for (int i = 0; i < NRES; i++) e[i] = relu_f($signed(v.exp[i*8 +: 8]));
        return e;
    endfunction

    // Collect transfers and check that a stalled result stays put.
    logic                    prev_stall = 1'b0;
    logic signed [WIDTH-1:0] prev_d = '0;
    logic                    prev_l = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_d);
                check("hold_last", out_last, prev_l);
            end
            if (out_valid && out_ready && !clear)
                got.push_back(obs_t'{d: out_data, l: out_last, beat: acc_cnt});
            prev_stall <= out_valid && !out_ready && !clear;
            prev_d     <= out_data;
            prev_l     <= out_last;
        end
    end

    task automatic push(input int v);
        in_valid = 1'b1;
        in_data  = 8'(v);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                acc_cnt++;
                if (rand_bp) out_ready = 1'($urandom_range(0, 1));
                return;
            end
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
        n_checks++;
        n_fail++;
        $display("FAIL push_timeout: pixel %0d never accepted", v);
        in_valid = 1'b0;
    endtask

    task automatic send(input frame_t f);
        for (int i = 0; i < NPIX; i++) push(f[i]);
    endtask

    task automatic drain();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input res_t e, input int base, input bit chk_beat);
        int beats [NRES] = '{6, 8, 14, 16};
        for (int j = 0; j < NRES; j++) begin
            if (base + j < got.size()) begin
                check($sformatf("%s_data%0d", name, j), got[base + j].d, e[j]);
                check($sformatf("%s_last%0d", name, j), got[base + j].l, (j == NRES - 1) ? 1 : 0);
                if (chk_beat) check($sformatf("%s_beat%0d", name, j), got[base + j].beat, beats[j]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs [3];
        frame_t s1, f, g;
        int     base;

        vecs[0] = mk('{1, 5, 3, 2, 2, 7, -1, 0, 4, 4, -8, -8, 0, 9, -2, -3}, '{7, 3, 9, -2});
        vecs[1] = mk('{default: -128}, '{default: -128});
        vecs[2] = mk('{127, -128, -1, -2, -128, -128, -3, -1, 0, -1, 5, 5, -1, -1, 5, 5},
                     '{127, -1, 0, 5});
        s1 = vframe(vecs[0]);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table vectors, out_ready held high
        for (int v = 0; v < 3; v++) begin
            base    = got.size();
            acc_cnt = 0;
            send(vframe(vecs[v]));
            drain();
            check($sformatf("vec%0d_count", v), got.size() - base, NRES);
            expect_out($sformatf("vec%0d", v), vexp(vecs[v]), base, v == 0);
        end

        // Backpressure right after the first result
        base = got.size();
        for (int i = 0; i < 6; i++) push(s1[i]);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'(s1[6]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, relu_f(7));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 6; i < NPIX; i++) push(s1[i]);
        drain();
        check("stall_count", got.size() - base, NRES);
        expect_out("stall", vexp(vecs[0]), base, 1'b0);

        // Two back-to-back frames, continuous input
        for (int i = 0; i < NPIX; i++) g[i] = int'($urandom_range(0, 255)) - 128;
        base = got.size();
        send(s1);
        send(g);
        drain();
        check("b2b_count", got.size() - base, 2 * NRES);
        expect_out("b2b_a", vexp(vecs[0]), base, 1'b0);
        expect_out("b2b_b", ref_pool(g), base + NRES, 1'b0);

        // clear after 6 pixels with a pending result and an input beat in the clear cycle
        base      = got.size();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(s1[i]);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'sd100;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("clear_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(s1);
        drain();
        check("clear_count", got.size() - base, NRES);
        expect_out("clear", vexp(vecs[0]), base, 1'b0);

        // clear while the engine is ready, so the beat in the clear cycle would be accepted
        base = got.size();
        for (int i = 0; i < 3; i++) push(s1[i]);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'sd77;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        send(s1);
        drain();
        check("clear2_count", got.size() - base, NRES);
        expect_out("clear2", vexp(vecs[0]), base, 1'b0);

        // Asynchronous reset mid-frame
        base = got.size();
        for (int i = 0; i < 5; i++) push(s1[i]);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(s1);
        drain();
        check("mid_rst_count", got.size() - base, NRES);
        expect_out("mid_rst", vexp(vecs[0]), base, 1'b0);

        // Randomized frames under random backpressure
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NPIX; i++) f[i] = int'($urandom_range(0, 255)) - 128;
            base    = got.size();
            rand_bp = 1'b1;
            send(f);
            drain();
            check($sformatf("rnd%0d_count", r), got.size() - base, NRES);
            expect_out($sformatf("rnd%0d", r), ref_pool(f), base, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
